// File: rtl/maxpool_scheduler.sv
// Sequencer for 2x2/stride-2 max pooling: fetches each window from the conv-output SRAM,
// presents it to the pooling datapath and writes the pooled word to the pool-output SRAM.
module maxpool_scheduler #(
  parameter int CH     = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CH*8-1:0]   rd_data,
  output logic [CH*16-1:0]  pixel_1and2,
  output logic [CH*8-1:0]   pixel_3,
  output logic [CH*8-1:0]   pixel_4,
  output logic [2:0]        curr_state_or,
  input  logic [CH*8-1:0]   ans,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH*8-1:0]   wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int DW     = CH * 8;
  localparam int LAST_C = (IMG_W / 2 - 1) * 2;
  localparam int LAST_R = (IMG_H / 2 - 1) * 2;
  localparam logic [ADDR_W-1:0] W_STEP    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2_STEP = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] LAST_C_A  = ADDR_W'(LAST_C);
  localparam logic [ADDR_W-1:0] LAST_R_A  = ADDR_W'(LAST_R);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_POOL, S_WR, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic [ADDR_W-1:0] row, col, row_off, out_idx;
  logic [ADDR_W-1:0] rd_off;
  logic [DW-1:0]     p1, p2, p3, p4, wr_data_q;
  logic              last_win;

  assign last_win = (row == LAST_R_A) && (col == LAST_C_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_base_q <= '0;
      wr_base_q <= '0;
      row       <= '0;
      col       <= '0;
      row_off   <= '0;
      out_idx   <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      p4        <= '0;
      wr_data_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          rd_base_q <= rd_base;
          wr_base_q <= wr_base;
          row       <= '0;
          col       <= '0;
          row_off   <= '0;
          out_idx   <= '0;
        end
        S_RD1:  p1 <= rd_data;
        S_RD2:  p2 <= rd_data;
        S_RD3:  p3 <= rd_data;
        S_CAP:  p4 <= rd_data;
        S_POOL: wr_data_q <= ans;
        S_WR: if (wr_ready) begin
          out_idx <= out_idx + 1'b1;
          // odd trailing column is skipped by wrapping at the last even-floor column
          if (col == LAST_C_A) begin
            col     <= '0;
            row     <= row + ADDR_W'(2);
            row_off <= row_off + ROW2_STEP;
          end else begin
            col <= col + ADDR_W'(2);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RD0;
      S_RD0:   state_nx = S_RD1;
      S_RD1:   state_nx = S_RD2;
      S_RD2:   state_nx = S_RD3;
      S_RD3:   state_nx = S_CAP;
      S_CAP:   state_nx = S_POOL;
      S_POOL:  state_nx = S_WR;
      S_WR:    if (wr_ready) state_nx = last_win ? S_DONE : S_RD0;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_off  = '0;
    rd_addr = '0;
    case (state)
      S_RD0: rd_en = 1'b1;
      S_RD1: begin rd_en = 1'b1; rd_off = ADDR_W'(1); end
      S_RD2: begin rd_en = 1'b1; rd_off = W_STEP; end
      S_RD3: begin rd_en = 1'b1; rd_off = W_STEP + ADDR_W'(1); end
      default: ;
    endcase
    if (rd_en) rd_addr = rd_base_q + row_off + col + rd_off;
  end

  always_comb begin
    pixel_1and2 = '0;
    for (int i = 0; i < CH; i++) begin
      pixel_1and2[i*16 +: 16] = {p2[i*8 +: 8], p1[i*8 +: 8]};
    end
  end

  assign pixel_3       = p3;
  assign pixel_4       = p4;
  assign curr_state_or = (state == S_POOL) ? 3'd4 : 3'd0;
  assign wr_en         = (state == S_WR);
  assign wr_addr       = wr_en ? (wr_base_q + out_idx) : '0;
  assign wr_data       = wr_data_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Randomized bench for maxpool_scheduler: SRAM + pooling datapath models around the DUT,
// expected reads/windows/writes computed per map from plain row/col arithmetic.
module tb_maxpool_scheduler;

  localparam int CH = 8, W = 5, H = 5, AW = 10, DW = CH * 8;
  localparam int NWIN = (W / 2) * (H / 2);

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_ready = 1'b1;
  logic [AW-1:0] rd_base = '0, wr_base = '0;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, pixel_3, pixel_4, ans, wr_data;
  logic [CH*16-1:0] pixel_1and2;
  logic [2:0]    curr_state_or;

  maxpool_scheduler #(.CH(CH), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_base(rd_base), .wr_base(wr_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pixel_1and2(pixel_1and2),
    .pixel_3(pixel_3), .pixel_4(pixel_4), .curr_state_or(curr_state_or), .ans(ans),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [DW-1:0] pool_max(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    logic signed [7:0] v;
    m = '0;
    for (int i = 0; i < CH; i++) begin
      v = a[i*8 +: 8];
      if ($signed(b[i*8 +: 8]) > v) v = b[i*8 +: 8];
      if ($signed(c[i*8 +: 8]) > v) v = c[i*8 +: 8];
      if ($signed(d[i*8 +: 8]) > v) v = d[i*8 +: 8];
      m[i*8 +: 8] = v;
    end
    return m;
  endfunction

  function automatic logic [CH*16-1:0] pack12(input logic [DW-1:0] a, b);
    logic [CH*16-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*16 +: 16] = {b[i*8 +: 8], a[i*8 +: 8]};
    return r;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [CH*16-1:0] x, input int hi);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*8 +: 8] = x[i*16 + hi*8 +: 8];
    return r;
  endfunction

  // behavioural pooling datapath fed from the DUT's pixel outputs
  always_comb ans = pool_max(lane(pixel_1and2, 0), lane(pixel_1and2, 1), pixel_3, pixel_4);

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_rd[$], exp_wa[$];
  logic [DW-1:0] exp_wd[$], exp_p1[$], exp_p2[$], exp_p3[$], exp_p4[$];
  logic [DW-1:0] got_wd [0:NWIN-1];
  int rd_idx, wr_idx, win_idx, stalls, cyc = 0, hold_n, stall_pct = 0;
  bit hold_first = 0, prev_stall = 0;
  logic [AW-1:0] prev_wa;
  logic [DW-1:0] prev_wd;

  task automatic build_model(input logic [AW-1:0] rb, input logic [AW-1:0] wb);
    logic [AW-1:0] a [4];
    int k = 0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    exp_p1.delete(); exp_p2.delete(); exp_p3.delete(); exp_p4.delete();
    for (int r = 0; r + 1 < H; r += 2)
      for (int c = 0; c + 1 < W; c += 2) begin
        a[0] = rb + AW'(r * W + c);
        a[1] = rb + AW'(r * W + c + 1);
        a[2] = rb + AW'((r + 1) * W + c);
        a[3] = rb + AW'((r + 1) * W + c + 1);
        for (int j = 0; j < 4; j++) exp_rd.push_back(a[j]);
        exp_p1.push_back(mem[a[0]]); exp_p2.push_back(mem[a[1]]);
        exp_p3.push_back(mem[a[2]]); exp_p4.push_back(mem[a[3]]);
        exp_wd.push_back(pool_max(mem[a[0]], mem[a[1]], mem[a[2]], mem[a[3]]));
        exp_wa.push_back(wb + AW'(k));
        k++;
      end
  endtask

  // one clock: drive wr_ready just after the edge, observe on the falling edge
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (hold_first && wr_en && wr_idx == 0 && hold_n < 5) begin
      wr_ready = 1'b0;
      hold_n++;
    end else if (stall_pct > 0) wr_ready = ($urandom_range(0, 99) >= stall_pct);
    else wr_ready = 1'b1;
    @(negedge clk);
    if (rst_n) begin
      if (rd_en) begin
        chk("rd_wr_excl", wr_en, 0);
        if (rd_idx < exp_rd.size()) chk("rd_addr", rd_addr, exp_rd[rd_idx]);
        else chk("rd_extra", rd_idx, exp_rd.size());
        rd_idx++;
      end
      if (curr_state_or != 3'd0) begin
        chk("pool_code", curr_state_or, 3'd4);
        if (win_idx < NWIN) begin
          chk("pix12_pool", pixel_1and2, pack12(exp_p1[win_idx], exp_p2[win_idx]));
          chk("pix3_pool", pixel_3, exp_p3[win_idx]);
          chk("pix4_pool", pixel_4, exp_p4[win_idx]);
        end
        win_idx++;
      end
      if (prev_stall) begin
        chk("stall_wr_en", wr_en, 1);
        chk("stall_wr_addr", wr_addr, prev_wa);
        chk("stall_wr_data", wr_data, prev_wd);
      end
      if (wr_en) begin
        if (wr_idx < NWIN) begin
          chk("pix12_wr", pixel_1and2, pack12(exp_p1[wr_idx], exp_p2[wr_idx]));
          chk("pix4_wr", pixel_4, exp_p4[wr_idx]);
        end
        if (!wr_ready) stalls++;
        else if (wr_idx < NWIN) begin
          chk("wr_addr", wr_addr, exp_wa[wr_idx]);
          chk("wr_data", wr_data, exp_wd[wr_idx]);
          got_wd[wr_idx] = wr_data;
          wr_idx++;
        end else begin
          chk("wr_extra", wr_idx, NWIN);
          wr_idx++;
        end
      end
      prev_stall = wr_en && !wr_ready;
      prev_wa = wr_addr;
      prev_wd = wr_data;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_pix12"}, pixel_1and2, 0);
    chk({tag, "_pix3"}, pixel_3, 0);
    chk({tag, "_pix4"}, pixel_4, 0);
    chk({tag, "_code"}, curr_state_or, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_map(input logic [AW-1:0] rb, input logic [AW-1:0] wb, input int spct,
                         input bit hold, input bit busy_start, input bit abort);
    int t0;
    build_model(rb, wb);
    rd_idx = 0; wr_idx = 0; win_idx = 0; stalls = 0; hold_n = 0; prev_stall = 0;
    stall_pct = spct; hold_first = hold;
    start = 1'b1; rd_base = rb; wr_base = wb;
    tick();
    start = 1'b0; rd_base = AW'($urandom); wr_base = AW'($urandom);
    t0 = cyc;
    chk("busy_after_start", busy, 1);
    if (abort) begin
      for (int k = 0; k < 50 && rd_idx < 7; k++) tick();
      chk("abort_reached_rd2", rd_idx, 7);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("abort");
      chk("abort_writes", wr_idx, 1);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("abort_idle", busy, 0);
      stall_pct = 0;
      return;
    end
    for (int k = 0; k < 2000; k++) begin
      if (busy_start && k == 10) begin
        start = 1'b1; rd_base = AW'($urandom); wr_base = AW'($urandom);
      end
      if (k == 11) start = 1'b0;
      tick();
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("done_cycle", cyc - t0, 7 * NWIN + stalls);
    chk("busy_in_done", busy, 1);
    chk("rd_count", rd_idx, 4 * NWIN);
    chk("wr_count", wr_idx, NWIN);
    chk("pool_count", win_idx, NWIN);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    repeat (3) tick();
    chk("no_restart", busy, 0);
    stall_pct = 0; hold_first = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    logic [AW-1:0] a;
    fill_random();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // ramp map: pixel (r,c) = r*W+c in every channel
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        a = AW'(100 + r * W + c);
        mem[a] = {CH{8'(r * W + c)}};
      end
    run_map(AW'(100), AW'(20), 0, 0, 0, 0);
    chk("ramp_w0", got_wd[0][7:0], 8'd6);
    chk("ramp_w1", got_wd[1][7:0], 8'd8);
    chk("ramp_w2", got_wd[2][63:56], 8'd16);
    chk("ramp_w3", got_wd[3][63:56], 8'd18);

    // signed window: ch0 {-128,-1,-5,-7}, ch7 {1,2,3,127}
    fill_random();
    a = AW'(200);       mem[a][7:0] = 8'h80; mem[a][63:56] = 8'd1;
    a = AW'(201);       mem[a][7:0] = 8'hFF; mem[a][63:56] = 8'd2;
    a = AW'(200 + W);   mem[a][7:0] = 8'hFB; mem[a][63:56] = 8'd3;
    a = AW'(201 + W);   mem[a][7:0] = 8'hF9; mem[a][63:56] = 8'd127;
    run_map(AW'(200), AW'(500), 0, 0, 0, 0);
    chk("signed_ch0", got_wd[0][7:0], 8'hFF);
    chk("signed_ch7", got_wd[0][63:56], 8'h7F);

    // wr_ready low for 5 cycles on the first write
    fill_random();
    run_map(AW'(300), AW'(40), 0, 1, 0, 0);
    chk("hold_stalls", stalls, 5);

    // start while busy, read window wrapping past the top of the address space
    fill_random();
    run_map(AW'(1020), AW'(1022), 0, 0, 1, 0);

    // reset during RD2 of window 1, then a fresh full scan
    fill_random();
    run_map(AW'(50), AW'(0), 0, 0, 0, 1);
    run_map(AW'(50), AW'(0), 0, 0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      fill_random();
      run_map(AW'($urandom), AW'($urandom), 30, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
